// File: rtl/mandelbrot_pkg.sv
// Shared types and fixed-point helpers for the Mandelbrot/Julia escape-time engine.
package mandelbrot_pkg;

    localparam int FP_WIDTH_D = 25;
    localparam int FP_INT_D   = 4;
    localparam int FRAC_D     = FP_WIDTH_D - FP_INT_D;
    localparam int ITERW_D    = 8;
    localparam int TAG_W_D    = 8;

    typedef enum logic [1:0] {IDLE, MUL, UPD, HOLD} eng_state_t;

    // Fixed-point 4.0 at the default fraction width, as a 64-bit signed value.
    localparam longint FOUR = 64'sd4 <<< FRAC_D;

    // Real-to-fixed conversion for constants and stimulus (elaboration/simulation only).
    function automatic longint fp_const(input real v, input int frac = FRAC_D);
        return longint'(v * (2.0 ** frac));
    endfunction

    // Three-operand add, clamped to a signed w-bit range.
    function automatic logic signed [63:0] sat_add3(input logic signed [63:0] a,
                                                    input logic signed [63:0] b,
                                                    input logic signed [63:0] c,
                                                    input int w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b + c;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    // Companion flag: 1 when sat_add3 with the same operands clamps.
    function automatic logic sat_hit3(input logic signed [63:0] a,
                                      input logic signed [63:0] b,
                                      input logic signed [63:0] c,
                                      input int w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b + c;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (s > hi) || (s < lo);
    endfunction

endpackage

// File: rtl/mandelbrot_engine_if.sv
// Job/result bus of the escape-time engine: master = scheduler side, slave = engine.
interface mandelbrot_engine_if #(
    parameter int FP_WIDTH = 25,
    parameter int ITERW    = 8,
    parameter int TAG_W    = 8
);
    // Both channels use valid/ready: a transfer happens on a clock edge where
    // valid && ready; valid and payload stay stable until that edge.
    logic                       in_valid;
    logic                       in_ready;
    logic signed [FP_WIDTH-1:0] in_re;
    logic signed [FP_WIDTH-1:0] in_im;
    logic [TAG_W-1:0]           in_tag;
    logic                       out_valid;
    logic                       out_ready;
    logic [ITERW-1:0]           out_iter;
    logic                       out_in_set;
    logic [TAG_W-1:0]           out_tag;

    modport master (
        output in_valid, in_re, in_im, in_tag, out_ready,
        input  in_ready, out_valid, out_iter, out_in_set, out_tag
    );

    modport slave (
        input  in_valid, in_re, in_im, in_tag, out_ready,
        output in_ready, out_valid, out_iter, out_in_set, out_tag
    );
endinterface

// File: rtl/mandelbrot_engine_fp_mul_sat.sv
// Registered signed fixed-point multiply: full product rescaled by FRAC, clamped to FP_WIDTH.
module fp_mul_sat #(
    parameter int FP_WIDTH = 25,
    parameter int FP_INT   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [FP_WIDTH-1:0] a,
    input  logic signed [FP_WIDTH-1:0] b,
    output logic signed [FP_WIDTH-1:0] val,
    output logic                       ovf
);
    localparam int FRAC = FP_WIDTH - FP_INT;
    localparam int PW   = 2 * FP_WIDTH;
    localparam int SW   = PW - FRAC;
    localparam logic signed [FP_WIDTH-1:0] MAXV = {1'b0, {(FP_WIDTH-1){1'b1}}};
    localparam logic signed [FP_WIDTH-1:0] MINV = {1'b1, {(FP_WIDTH-1){1'b0}}};

    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] scaled;
    logic [FP_INT:0]      head;
    logic                 fits;

    // The result fits when every bit above the kept sign bit copies it.
    always_comb begin
        prod   = PW'(a) * PW'(b);
        scaled = SW'(prod >>> FRAC);
        head   = scaled[SW-1:FP_WIDTH-1];
        fits   = (&head) || !(|head);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val <= '0;
            ovf <= 1'b0;
        end else if (fits) begin
            val <= scaled[FP_WIDTH-1:0];
            ovf <= 1'b0;
        end else begin
            val <= scaled[SW-1] ? MINV : MAXV;
            ovf <= 1'b1;
        end
    end
endmodule

// File: rtl/mandelbrot_engine.sv
// Escape-time iterator for Mandelbrot/Julia sets, two cycles per iteration, tagged jobs.
module mandelbrot_engine
    import mandelbrot_pkg::*;
#(
    parameter int FP_WIDTH = 25,
    parameter int FP_INT   = 4,
    parameter int ITERW    = 8,
    parameter int TAG_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    mandelbrot_engine_if.slave         bus,
    input  logic                       julia,
    input  logic signed [FP_WIDTH-1:0] c_re,
    input  logic signed [FP_WIDTH-1:0] c_im,
    input  logic [ITERW-1:0]           iter_max,
    output logic                       busy,
    output eng_state_t                 dbg_state
);
    localparam int FRAC = FP_WIDTH - FP_INT;
    localparam logic signed [FP_WIDTH:0] FOUR_W = (FP_WIDTH+1)'(4 << FRAC);

    eng_state_t state_q, state_d;

    logic signed [FP_WIDTH-1:0] x_q, y_q, cr_q, ci_q;
    logic signed [FP_WIDTH-1:0] x2, y2, xy;
    logic                       ovf_x2, ovf_y2, ovf_xy;
    logic [ITERW-1:0]           iter_q, iter_max_q, out_iter_q;
    logic [TAG_W-1:0]           tag_q, out_tag_q;
    logic                       z_ovf_q, out_in_set_q;

    logic                       accept;
    logic signed [FP_WIDTH:0]   sum_sq;
    logic                       escape;
    logic                       at_limit;

    fp_mul_sat #(.FP_WIDTH(FP_WIDTH), .FP_INT(FP_INT)) u_mul_x2 (
        .clk(clk), .rst(rst), .a(x_q), .b(x_q), .val(x2), .ovf(ovf_x2));
    fp_mul_sat #(.FP_WIDTH(FP_WIDTH), .FP_INT(FP_INT)) u_mul_y2 (
        .clk(clk), .rst(rst), .a(y_q), .b(y_q), .val(y2), .ovf(ovf_y2));
    fp_mul_sat #(.FP_WIDTH(FP_WIDTH), .FP_INT(FP_INT)) u_mul_xy (
        .clk(clk), .rst(rst), .a(x_q), .b(y_q), .val(xy), .ovf(ovf_xy));

    // The magnitude sum carries one extra bit so it never wraps; 4.0 itself stays bounded.
    always_comb begin
        accept   = bus.in_valid && (state_q == IDLE);
        sum_sq   = {x2[FP_WIDTH-1], x2} + {y2[FP_WIDTH-1], y2};
        escape   = z_ovf_q || ovf_x2 || ovf_y2 || ovf_xy || (sum_sq > FOUR_W);
        at_limit = (iter_q == iter_max_q);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MUL;
            MUL:     state_d = UPD;
            UPD:     state_d = (escape || at_limit) ? HOLD : MUL;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            cr_q         <= '0;
            ci_q         <= '0;
            iter_q       <= '0;
            iter_max_q   <= '0;
            tag_q        <= '0;
            z_ovf_q      <= 1'b0;
            out_iter_q   <= '0;
            out_in_set_q <= 1'b0;
            out_tag_q    <= '0;
        end else begin
            if (accept) begin
                x_q        <= julia ? bus.in_re : '0;
                y_q        <= julia ? bus.in_im : '0;
                cr_q       <= julia ? c_re : bus.in_re;
                ci_q       <= julia ? c_im : bus.in_im;
                iter_q     <= '0;
                iter_max_q <= iter_max;
                tag_q      <= bus.in_tag;
                z_ovf_q    <= 1'b0;
            end
            if (state_q == UPD) begin
                if (escape || at_limit) begin
                    out_iter_q   <= iter_q;
                    out_in_set_q <= !escape;
                    out_tag_q    <= tag_q;
                end else begin
                    x_q     <= FP_WIDTH'(sat_add3(64'(x2), -64'(y2), 64'(cr_q), FP_WIDTH));
                    y_q     <= FP_WIDTH'(sat_add3(64'(xy), 64'(xy), 64'(ci_q), FP_WIDTH));
                    z_ovf_q <= sat_hit3(64'(x2), -64'(y2), 64'(cr_q), FP_WIDTH) ||
                               sat_hit3(64'(xy), 64'(xy), 64'(ci_q), FP_WIDTH);
                    iter_q  <= iter_q + ITERW'(1);
                end
            end
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.out_iter   = out_iter_q;
    assign bus.out_in_set = out_in_set_q;
    assign bus.out_tag    = out_tag_q;
    assign busy           = (state_q != IDLE);
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_mandelbrot_engine.sv
// Directed and randomized bench for mandelbrot_engine with a plain-arithmetic escape-time model.
module tb_mandelbrot_engine;
    import mandelbrot_pkg::*;

    localparam int W  = 25;
    localparam int IW = 8;
    localparam int TW = 8;
    localparam longint MAXV = (64'sd1 <<< (W - 1)) - 64'sd1;
    localparam longint MINV = -(64'sd1 <<< (W - 1));

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                julia = 1'b0;
    logic signed [W-1:0] c_re = '0;
    logic signed [W-1:0] c_im = '0;
    logic [IW-1:0]       iter_max = '0;
    logic                busy;
    eng_state_t          dbg_state;

    mandelbrot_engine_if #(.FP_WIDTH(W), .ITERW(IW), .TAG_W(TW)) bus ();

    mandelbrot_engine #(.FP_WIDTH(W), .FP_INT(4), .ITERW(IW), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .julia(julia), .c_re(c_re), .c_im(c_im),
        .iter_max(iter_max), .busy(busy), .dbg_state(dbg_state));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [TW+IW:0] exp_q[$];   // {tag, in_set, iter}

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint clamp(input longint v, inout bit hit);
        if (v > MAXV) begin hit = 1'b1; return MAXV; end
        if (v < MINV) begin hit = 1'b1; return MINV; end
        return v;
    endfunction

    function automatic logic [IW:0] model(input longint re, input longint im, input bit jul,
                                          input longint cre, input longint cim, input int imax);
        longint zx, zy, cx, cy, x2, y2, xy;
        bit ovf_upd, ovf;
        zx = jul ? re : 0;
        zy = jul ? im : 0;
        cx = jul ? cre : re;
        cy = jul ? cim : im;
        ovf_upd = 1'b0;
        for (int it = 0; it <= imax; it++) begin
            ovf = ovf_upd;
            x2 = clamp((zx * zx) >>> FRAC_D, ovf);
            y2 = clamp((zy * zy) >>> FRAC_D, ovf);
            xy = clamp((zx * zy) >>> FRAC_D, ovf);
            if (ovf || (x2 + y2 > FOUR)) return {1'b0, IW'(it)};
            if (it == imax) return {1'b1, IW'(it)};
            ovf_upd = 1'b0;
            zx = clamp(x2 - y2 + cx, ovf_upd);
            zy = clamp(2 * xy + cy, ovf_upd);
        end
        return '0;
    endfunction

    function automatic longint fx(input real r);
        return fp_const(r);
    endfunction

    // ---------------- drivers ----------------
    task automatic send_job(input longint re, input longint im, input logic [TW-1:0] tag,
                            input bit jul, input longint cre, input longint cim, input int imax);
        int n;
        bit ok;
        bus.in_re  = W'(re);
        bus.in_im  = W'(im);
        bus.in_tag = tag;
        julia      = jul;
        c_re       = W'(cre);
        c_im       = W'(cim);
        iter_max   = IW'(imax);
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 500) begin tick(); n++; end
        ok = bus.in_ready;
        tick();
        bus.in_valid = 1'b0;
        check("accept_timeout", ok, 1);
    endtask

    task automatic issue_model(input longint re, input longint im, input logic [TW-1:0] tag,
                               input bit jul, input longint cre, input longint cim, input int imax);
        exp_q.push_back({tag, model(re, im, jul, cre, cim, imax)});
        send_job(re, im, tag, jul, cre, cim, imax);
    endtask

    // ---------------- scoreboard / receiver ----------------
    task automatic recv(input bit chk_lat, input int min_stall, input int max_stall);
        int cyc;
        int stall;
        bit stable;
        logic [TW+IW:0] e;
        cyc = 0;
        while (!bus.out_valid && cyc < 3000) begin tick(); cyc++; end
        check("out_valid_timeout", bus.out_valid, 1);
        if (!bus.out_valid) return;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=result expected=none");
            return;
        end
        e = exp_q.pop_front();
        if (chk_lat) check("latency", cyc, 2 * (int'(e[IW-1:0]) + 1));
        check("out_iter", bus.out_iter, e[IW-1:0]);
        check("out_in_set", bus.out_in_set, e[IW]);
        check("out_tag", bus.out_tag, e[TW+IW:IW+1]);
        stall = $urandom_range(min_stall, max_stall);
        if (stall > 0) begin
            bus.out_ready = 1'b0;
            stable = 1'b1;
            repeat (stall) begin
                tick();
                if (bus.out_valid !== 1'b1 || bus.out_iter !== e[IW-1:0] ||
                    bus.out_in_set !== e[IW] || bus.out_tag !== e[TW+IW:IW+1] ||
                    bus.in_ready !== 1'b0)
                    stable = 1'b0;
            end
            check("hold_stable", stable, 1);
        end
        bus.out_ready = 1'b1;
        tick();
        check("valid_drop", bus.out_valid, 0);
        check("ready_back", bus.in_ready, 1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit seen;
        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_iter", bus.out_iter, 0);
        check("rst_out_in_set", bus.out_in_set, 0);
        check("rst_out_tag", bus.out_tag, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_state", dbg_state, IDLE);
        rst = 1'b0;
        tick();

        // Mandelbrot c=0 stays in the set until the limit.
        exp_q.push_back({8'h01, 1'b1, 8'd100});
        send_job(0, 0, 8'h01, 1'b0, 0, 0, 100);
        recv(1, 0, 0);

        // c=1 escapes after 3; c=2 touches exactly 4.0 without escaping, then escapes.
        exp_q.push_back({8'h02, 1'b0, 8'd3});
        send_job(fx(1.0), 0, 8'h02, 1'b0, 0, 0, 255);
        recv(1, 0, 0);
        exp_q.push_back({8'h03, 1'b0, 8'd2});
        send_job(fx(2.0), 0, 8'h03, 1'b0, 0, 0, 255);
        recv(1, 0, 0);

        // Julia c=0.
        exp_q.push_back({8'h04, 1'b0, 8'd0});
        send_job(fx(2.0), fx(0.5), 8'h04, 1'b1, 0, 0, 50);
        recv(1, 0, 0);
        exp_q.push_back({8'h05, 1'b1, 8'd20});
        send_job(fx(0.5), 0, 8'h05, 1'b1, 0, 0, 20);
        recv(1, 0, 0);

        // Backpressure for 20 cycles.
        exp_q.push_back({8'h06, 1'b0, 8'd3});
        send_job(fx(1.0), 0, 8'h06, 1'b0, 0, 0, 255);
        recv(1, 20, 20);

        // Back-to-back tagged jobs; the second offer changes julia/iter_max while the first runs.
        exp_q.push_back({8'h11, 1'b1, 8'd12});
        send_job(fx(0.25), 0, 8'h11, 1'b0, 0, 0, 12);
        exp_q.push_back({8'h22, 1'b0, 8'd0});
        fork
            send_job(fx(2.0), fx(0.5), 8'h22, 1'b1, 0, 0, 1);
            recv(0, 0, 0);
        join
        recv(1, 0, 0);

        // Reset in the middle of a long job.
        send_job(0, 0, 8'h33, 1'b0, 0, 0, 100);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        seen = 1'b0;
        repeat (250) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("midrst_no_result", seen, 0);

        // Reset and an offered job in the same cycle: the job is dropped.
        bus.in_re    = W'(fx(1.0));
        bus.in_valid = 1'b1;
        rst          = 1'b1;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_vs_valid_busy", busy, 0);
        check("rst_vs_valid_state", dbg_state, IDLE);
        tick();
        check("rst_vs_valid_idle", busy, 0);

        // Randomized jobs against the model, with random result backpressure.
        for (int j = 0; j < 40; j++) begin
            longint re, im, cre, cim;
            re  = longint'($urandom_range(0, 1 << 24)) - (64'sd1 <<< 23);
            im  = longint'($urandom_range(0, 1 << 24)) - (64'sd1 <<< 23);
            cre = longint'($urandom_range(0, 1 << 22)) - (64'sd1 <<< 21);
            cim = longint'($urandom_range(0, 1 << 22)) - (64'sd1 <<< 21);
            issue_model(re, im, TW'($urandom_range(0, 255)), bit'($urandom_range(0, 1)),
                        cre, cim, $urandom_range(0, 40));
            recv(1, 0, 3);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
